// File: rtl/operand_fetch.sv
// Operand-fetch / issue stage: register file addressing, writeback bypass,
// pending-write scoreboard with RAW/WAW stalls, and a one-entry issue register.
module operand_fetch #(
  parameter int OPW  = 8,
  parameter int CNTW = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [OPW-1:0]  in_op,
  input  logic [4:0]      in_rs1,
  input  logic [4:0]      in_rs2,
  input  logic [4:0]      in_rd,
  input  logic            in_wen,
  output logic [4:0]      rdaddr1,
  output logic [4:0]      rdaddr2,
  input  logic [31:0]     rddata1,
  input  logic [31:0]     rddata2,
  input  logic            wb_valid,
  input  logic [4:0]      wb_addr,
  input  logic [31:0]     wb_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [OPW-1:0]  out_op,
  output logic [4:0]      out_rd,
  output logic            out_wen,
  output logic [31:0]     out_a,
  output logic [31:0]     out_b,
  output logic            err,
  output logic [CNTW-1:0] stall_cnt
);

  localparam logic [CNTW-1:0] CNT_MAX = {CNTW{1'b1}};
  localparam logic [CNTW-1:0] CNT_ONE = {{(CNTW-1){1'b0}}, 1'b1};

  function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_ONE;
  endfunction

  logic            out_valid_q, out_valid_d;
  logic [OPW-1:0]  out_op_q,    out_op_d;
  logic [4:0]      out_rd_q,    out_rd_d;
  logic            out_wen_q,   out_wen_d;
  logic [31:0]     out_a_q,     out_a_d;
  logic [31:0]     out_b_q,     out_b_d;
  logic [31:0]     busy_q,      busy_d;
  logic            err_q,       err_d;
  logic [CNTW-1:0] stall_cnt_q, stall_cnt_d;

  logic        wb_live;
  logic        rs1_hit, rs2_hit, rd_hit;
  logic        rs1_ok, rs2_ok, waw_ok;
  logic        space, ready, accept;
  logic [31:0] opa, opb;

  assign rdaddr1 = in_rs1;
  assign rdaddr2 = in_rs2;

  // Writebacks to r0 are architecturally invisible, so they neither bypass nor clear.
  assign wb_live = wb_valid && (wb_addr != 5'd0);

  assign rs1_hit = wb_live && (wb_addr == in_rs1);
  assign rs2_hit = wb_live && (wb_addr == in_rs2);
  assign rd_hit  = wb_live && (wb_addr == in_rd);

  assign rs1_ok = (in_rs1 == 5'd0) || !busy_q[in_rs1] || rs1_hit;
  assign rs2_ok = (in_rs2 == 5'd0) || !busy_q[in_rs2] || rs2_hit;
  assign waw_ok = !in_wen || (in_rd == 5'd0) || !busy_q[in_rd] || rd_hit;

  assign space  = !out_valid_q || out_ready;
  assign ready  = !rst && space && rs1_ok && rs2_ok && waw_ok;
  assign accept = in_valid && ready;

  // The regfile write lands at the edge, so a same-cycle writeback must be forwarded.
  assign opa = (in_rs1 == 5'd0) ? 32'd0 : (rs1_hit ? wb_data : rddata1);
  assign opb = (in_rs2 == 5'd0) ? 32'd0 : (rs2_hit ? wb_data : rddata2);

  always_comb begin
    out_valid_d = out_valid_q;
    out_op_d    = out_op_q;
    out_rd_d    = out_rd_q;
    out_wen_d   = out_wen_q;
    out_a_d     = out_a_q;
    out_b_d     = out_b_q;
    busy_d      = busy_q;
    err_d       = err_q;
    stall_cnt_d = stall_cnt_q;

    if (accept) begin
      out_valid_d = 1'b1;
      out_op_d    = in_op;
      out_rd_d    = in_rd;
      out_wen_d   = in_wen;
      out_a_d     = opa;
      out_b_d     = opb;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    if (wb_live) begin
      if (!busy_q[wb_addr]) err_d = 1'b1;
      busy_d[wb_addr] = 1'b0;
    end
    // Set after clear so a new producer of the retiring register stays pending.
    if (accept && in_wen && (in_rd != 5'd0)) busy_d[in_rd] = 1'b1;

    if (in_valid && !ready) stall_cnt_d = sat_inc(stall_cnt_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_op_q    <= '0;
      out_rd_q    <= 5'd0;
      out_wen_q   <= 1'b0;
      out_a_q     <= 32'd0;
      out_b_q     <= 32'd0;
      busy_q      <= 32'd0;
      err_q       <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_op_q    <= out_op_d;
      out_rd_q    <= out_rd_d;
      out_wen_q   <= out_wen_d;
      out_a_q     <= out_a_d;
      out_b_q     <= out_b_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign in_ready  = ready;
  assign out_valid = out_valid_q;
  assign out_op    = out_op_q;
  assign out_rd    = out_rd_q;
  assign out_wen   = out_wen_q;
  assign out_a     = out_a_q;
  assign out_b     = out_b_q;
  assign err       = err_q;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch with a behavioural 32x32 register file.
module tb_operand_fetch;
  localparam int OPW  = 8;
  localparam int CNTW = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid, in_ready;
  logic [OPW-1:0]  in_op;
  logic [4:0]      in_rs1, in_rs2, in_rd;
  logic            in_wen;
  logic [4:0]      rdaddr1, rdaddr2;
  logic [31:0]     rddata1, rddata2;
  logic            wb_valid;
  logic [4:0]      wb_addr;
  logic [31:0]     wb_data;
  logic            out_valid, out_ready;
  logic [OPW-1:0]  out_op;
  logic [4:0]      out_rd;
  logic            out_wen;
  logic [31:0]     out_a, out_b;
  logic            err;
  logic [CNTW-1:0] stall_cnt;

  logic [31:0] rf [32];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  operand_fetch #(.OPW(OPW), .CNTW(CNTW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_wen(in_wen),
    .rdaddr1(rdaddr1), .rdaddr2(rdaddr2), .rddata1(rddata1), .rddata2(rddata2),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_op(out_op),
    .out_rd(out_rd), .out_wen(out_wen), .out_a(out_a), .out_b(out_b),
    .err(err), .stall_cnt(stall_cnt)
  );

  // Regfile: r0 holds junk on purpose; the stage must not expose it.
  assign rddata1 = rf[rdaddr1];
  assign rddata2 = rf[rdaddr2];
  always @(posedge clk)
    if (wb_valid && wb_addr != 5'd0) rf[wb_addr] <= wb_data;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [7:0] op, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rd, input logic wen);
    in_valid = 1'b1; in_op = op; in_rs1 = rs1; in_rs2 = rs2; in_rd = rd; in_wen = wen;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = 32'h100 + i;
    rf[0] = 32'h5555_5555;
    rf[3] = 32'h11;
    rf[4] = 32'h22;
    rst = 1'b1; out_ready = 1'b1;
    wb_valid = 1'b0; wb_addr = 5'd0; wb_data = 32'd0;
    issue(8'h99, 5'd3, 5'd4, 5'd6, 1'b1);
    #1;
    chk("ready_in_reset", {31'd0, in_ready}, 32'd0);
    tick(); tick();
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_stall_cnt", {28'd0, stall_cnt}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_out_a", out_a, 32'd0);

    // Plain issue, no write
    rst = 1'b0;
    issue(8'hA1, 5'd3, 5'd4, 5'd1, 1'b0);
    #1;
    chk("rdaddr1", {27'd0, rdaddr1}, 32'd3);
    chk("rdaddr2", {27'd0, rdaddr2}, 32'd4);
    chk("ready_basic", {31'd0, in_ready}, 32'd1);
    tick();
    chk("basic_valid", {31'd0, out_valid}, 32'd1);
    chk("basic_a", out_a, 32'h11);
    chk("basic_b", out_b, 32'h22);
    chk("basic_op", {24'd0, out_op}, 32'hA1);

    // Producer of r5, then dependent consumer stalls
    issue(8'hB2, 5'd1, 5'd2, 5'd5, 1'b1);
    #1;
    chk("ready_producer", {31'd0, in_ready}, 32'd1);
    tick();
    chk("producer_rd", {27'd0, out_rd}, 32'd5);
    chk("producer_wen", {31'd0, out_wen}, 32'd1);
    issue(8'hC3, 5'd5, 5'd2, 5'd1, 1'b0);
    #1;
    chk("raw_stall", {31'd0, in_ready}, 32'd0);
    tick(); tick();
    chk("stall_cnt_2", {28'd0, stall_cnt}, 32'd2);
    chk("drained", {31'd0, out_valid}, 32'd0);

    // Writeback releases the consumer the same cycle via bypass
    wb_valid = 1'b1; wb_addr = 5'd5; wb_data = 32'hDEADBEEF;
    #1;
    chk("ready_bypass", {31'd0, in_ready}, 32'd1);
    tick();
    wb_valid = 1'b0;
    chk("bypass_a", out_a, 32'hDEADBEEF);
    chk("bypass_b", out_b, 32'h102);
    chk("stall_cnt_hold", {28'd0, stall_cnt}, 32'd2);
    issue(8'hC4, 5'd5, 5'd5, 5'd0, 1'b1);
    #1;
    chk("busy5_cleared", {31'd0, in_ready}, 32'd1);
    tick();
    chk("rf5_a", out_a, 32'hDEADBEEF);
    chk("err_after_wb5", {31'd0, err}, 32'd0);

    // r0 reads and writebacks are ignored
    issue(8'hE5, 5'd0, 5'd0, 5'd0, 1'b1);
    wb_valid = 1'b1; wb_addr = 5'd0; wb_data = 32'hFFFFFFFF;
    #1;
    chk("ready_r0", {31'd0, in_ready}, 32'd1);
    tick();
    wb_valid = 1'b0;
    chk("r0_a", out_a, 32'd0);
    chk("r0_b", out_b, 32'd0);
    chk("r0_err", {31'd0, err}, 32'd0);

    // Backpressure holds the issue register, then back-to-back issue
    out_ready = 1'b0;
    issue(8'hD4, 5'd3, 5'd4, 5'd1, 1'b0);
    #1;
    chk("bp_not_ready", {31'd0, in_ready}, 32'd0);
    tick();
    chk("bp_valid", {31'd0, out_valid}, 32'd1);
    chk("bp_op_held", {24'd0, out_op}, 32'hE5);
    chk("bp_a_held", out_a, 32'd0);
    out_ready = 1'b1;
    #1;
    chk("bp_release", {31'd0, in_ready}, 32'd1);
    tick();
    chk("b2b1_op", {24'd0, out_op}, 32'hD4);
    chk("b2b1_a", out_a, 32'h11);
    issue(8'hF6, 5'd4, 5'd3, 5'd2, 1'b0);
    tick();
    chk("b2b2_op", {24'd0, out_op}, 32'hF6);
    chk("b2b2_a", out_a, 32'h22);
    chk("b2b2_b", out_b, 32'h11);
    chk("b2b2_valid", {31'd0, out_valid}, 32'd1);
    chk("stall_cnt_3", {28'd0, stall_cnt}, 32'd3);

    // Set wins over a same-cycle clear on r7
    issue(8'h17, 5'd1, 5'd1, 5'd7, 1'b1);
    tick();
    issue(8'h27, 5'd1, 5'd1, 5'd7, 1'b1);
    wb_valid = 1'b1; wb_addr = 5'd7; wb_data = 32'h77;
    #1;
    chk("waw_resolved", {31'd0, in_ready}, 32'd1);
    tick();
    wb_valid = 1'b0;
    chk("waw_op", {24'd0, out_op}, 32'h27);
    chk("err_wb7", {31'd0, err}, 32'd0);
    issue(8'h37, 5'd7, 5'd0, 5'd1, 1'b0);
    #1;
    chk("busy7_kept", {31'd0, in_ready}, 32'd0);

    // Writeback to an idle register raises a sticky error
    in_valid = 1'b0;
    wb_valid = 1'b1; wb_addr = 5'd9; wb_data = 32'h9;
    tick();
    wb_valid = 1'b0;
    chk("err_set", {31'd0, err}, 32'd1);
    tick();
    chk("err_sticky", {31'd0, err}, 32'd1);

    // Permanent hazard saturates the stall counter
    issue(8'h47, 5'd7, 5'd0, 5'd1, 1'b0);
    for (int i = 0; i < (1 << CNTW) + 5; i++) tick();
    chk("stall_sat", {28'd0, stall_cnt}, 32'd15);
    chk("sat_not_ready", {31'd0, in_ready}, 32'd0);

    // Reset mid-operation
    rst = 1'b1;
    #1;
    chk("ready_rst_mid", {31'd0, in_ready}, 32'd0);
    tick();
    chk("rst2_valid", {31'd0, out_valid}, 32'd0);
    chk("rst2_op", {24'd0, out_op}, 32'd0);
    chk("rst2_rd", {27'd0, out_rd}, 32'd0);
    chk("rst2_wen", {31'd0, out_wen}, 32'd0);
    chk("rst2_a", out_a, 32'd0);
    chk("rst2_b", out_b, 32'd0);
    chk("rst2_err", {31'd0, err}, 32'd0);
    chk("rst2_stall", {28'd0, stall_cnt}, 32'd0);
    rst = 1'b0;
    #1;
    chk("busy_cleared", {31'd0, in_ready}, 32'd1);
    tick();
    chk("post_rst_a", out_a, 32'h77);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/operand_fetch.md
# operand_fetch

Operand-fetch/issue stage sitting directly upstream of the 32x32 register file and downstream of decode. It drives the register file read addresses, captures the two operands with same-cycle writeback bypass, tracks pending writes in a 32-bit scoreboard, and stalls decode on RAW/WAW hazards. Accepted instructions are held in a one-entry output register with valid/ready handshake toward execute.

## Interface
- OPW, 8: width of opaque opcode/control field passed through to execute
- CNTW, 16: width of saturating stall counter
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous reset, active-high
- in_valid  in  1  decode presents an instruction
- in_ready  out  1  stage accepts instruction this cycle
- in_op  in  OPW  opaque control field
- in_rs1, in_rs2  in  5  source register indices
- in_rd  in  5  destination register index
- in_wen  in  1  instruction will write in_rd
- rdaddr1, rdaddr2  out  5  register file read addresses
- rddata1, rddata2  in  32  register file read data (combinational from rdaddr)
- wb_valid  in  1  writeback retiring a result this cycle (same strobe drives regfile write)
- wb_addr  in  5  writeback destination index
- wb_data  in  32  writeback data
- out_valid  out  1  issued instruction valid toward execute
- out_ready  in  1  execute accepts
- out_op  out  OPW; out_rd  out  5; out_wen  out  1; out_a, out_b  out  32  registered issue fields
- err  out  1  sticky: writeback to a register not marked busy
- stall_cnt  out  CNTW  saturating count of stalled cycles

## Operation
- rdaddr1 = in_rs1, rdaddr2 = in_rs2, combinational, regardless of in_valid.
- Register 0: reads yield 0 (rddata and bypass ignored); in_wen with in_rd=0 never sets busy; r0 never a hazard source.
- Bypass per operand X: if rsX!=0 && wb_valid && wb_addr==rsX, operand = wb_data; else rddata. Needed because regfile write lands at the clock edge and the combinational read returns the old value that cycle.
- Hazard-free per source: rsX==0 || !busy[rsX] || (wb_valid && wb_addr==rsX).
- WAW-free: !in_wen || in_rd==0 || !busy[in_rd] || (wb_valid && wb_addr==in_rd).
- space = !out_valid || out_ready.
- in_ready = !rst && space && both sources hazard-free && WAW-free. Accept = in_valid && in_ready.
- On accept: out_op/out_rd/out_wen/out_a/out_b load; out_valid<=1; if in_wen && in_rd!=0, busy[in_rd]<=1.
- If out_valid && out_ready && !accept: out_valid<=0; data fields hold.
- wb_valid && wb_addr!=0: busy[wb_addr]<=0. If also set by accept to the same index the same cycle, set wins (busy stays 1).
- wb_valid && wb_addr!=0 && !busy[wb_addr]: err<=1, held until rst; busy unchanged.
- stall_cnt increments when in_valid && !in_ready && !rst; saturates at 2^CNTW-1.

## Timing
- Reset values: out_valid=0, out_op=0, out_rd=0, out_wen=0, out_a=0, out_b=0, busy=0, err=0, stall_cnt=0; in_ready=0 while rst high.
- rst mid-operation: pending out_valid dropped, scoreboard cleared next edge; no accept in a reset cycle.
- Latency: accept at edge N -> out_valid high after edge N, data stable until handshake.
- Throughput: 1 instruction/cycle with out_ready held high and no hazards.
- in_ready is combinational from in_*, busy, wb_*, out_valid, out_ready; no combinational path from in_valid to in_ready.
- Dependent instruction issues in the same cycle its producer's wb_valid is seen, using wb_data.

## Test plan
- Reset then issue rs1=3, rs2=4 with regfile r3=0x11, r4=0x22, in_wen=0 -> out_a=0x11, out_b=0x22 one cycle later, busy unchanged.
- Issue rd=5 in_wen=1; next issue rs1=5 -> in_ready=0, stall_cnt counts; assert wb_valid wb_addr=5 wb_data=0xDEADBEEF -> issues that cycle with out_a=0xDEADBEEF, busy[5] cleared.
- Issue rs1=0, rs2=0 while wb_valid wb_addr=0 wb_data=0xFFFFFFFF -> out_a=out_b=0, err stays 0.
- out_ready=0 with out_valid=1, in_valid=1 hazard-free -> in_ready=0, out fields stable; out_ready=1 -> back-to-back accept.
- busy[7]=1, wb_valid wb_addr=7 same cycle as accept with in_rd=7 in_wen=1 -> accepted, busy[7]=1 after edge; wb_valid wb_addr=9 with busy[9]=0 -> err=1 until rst.
- Hold in_valid with permanent hazard 2^CNTW+5 cycles -> stall_cnt saturates at 2^CNTW-1; assert rst -> all outputs at reset values next cycle.
